microseq_ctrl: RTL

Programmable microcoded control sequencer that drives the datapath control word (ALU op, mux A/B selects, register select, write enable) from a writable micro-instruction store. It replaces hard-coded per-algorithm state machines. Instructions branch on the datapath flags `zero`, `neg` and `mayor`, and a loop counter supports iterative algorithms such as shift-add multiply or restoring divide. It sits between the top-level start/done handshake and the datapath.

---
 rtl/microseq_pkg.sv | 56 +++++
 rtl/microseq_store.sv | 31 +++
 rtl/microseq_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/microseq_pkg.sv
// Shared encodings and micro-instruction field layout for the micro-sequencer.
// Word layout (MSB->LSB): cw[CW_W] | op[3] | cond[2] | pol[1] | target[ADDR_W].
package microseq_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned COND_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_NEXT   = 3'd0,
    OP_JUMP   = 3'd1,
    OP_BRANCH = 3'd2,
    OP_LDLOOP = 3'd3,
    OP_LOOP   = 3'd4,
    OP_WAIT   = 3'd5,
    OP_END    = 3'd6,
    OP_ILL    = 3'd7
  } op_e;

  typedef enum logic [COND_W-1:0] {
    COND_ZERO  = 2'd0,
    COND_NEG   = 2'd1,
    COND_MAYOR = 2'd2,
    COND_ONE   = 2'd3
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned mi_width(int unsigned cw_w, int unsigned addr_w);
    return cw_w + OP_W + COND_W + 1 + addr_w;
  endfunction

  function automatic int unsigned target_lsb();
    return 0;
  endfunction

  function automatic int unsigned pol_lsb(int unsigned addr_w);
    return addr_w;
  endfunction

  function automatic int unsigned cond_lsb(int unsigned addr_w);
    return addr_w + 1;
  endfunction

  function automatic int unsigned op_lsb(int unsigned addr_w);
    return addr_w + 1 + COND_W;
  endfunction

  function automatic int unsigned cw_lsb(int unsigned addr_w);
    return addr_w + 1 + COND_W + OP_W;
  endfunction

endpackage

// File: rtl/microseq_store.sv
// Micro-instruction store: 2^ADDR_W x MI_W array, synchronous write, asynchronous read.
// Contents are not reset.
//   clk   : clock
//   we    : write strobe (already qualified by the caller)
//   waddr : write address        wdata : write data
//   raddr : read address         rdata : read data (combinational)
module microseq_store #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned MI_W   = 28
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [MI_W-1:0]   wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [MI_W-1:0]   rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [MI_W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port
  assign rdata = mem[raddr];

endmodule

// File: rtl/microseq_ctrl.sv
// Microcoded control sequencer: steps through a writable micro-store and drives
// the datapath control word, branching on datapath flags and a loop counter.
//   clk, rst (async active-low)
//   start/start_addr : launch request (IDLE only)    abort : return to IDLE
//   zero/neg/mayor   : datapath flags                 ucode_* : store write port (IDLE only)
//   o_signal : control word (RUN only, else 0)        busy : in RUN
//   done     : one-cycle completion pulse             err  : sticky illegal-op flag
//   pc       : current micro-address
module microseq_ctrl
  import microseq_pkg::*;
#(
  parameter  int unsigned CW_W   = 16,
  parameter  int unsigned ADDR_W = 6,
  parameter  int unsigned LOOP_W = 4,
  localparam int unsigned MI_W   = CW_W + 6 + ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              abort,
  input  logic              zero,
  input  logic              neg,
  input  logic              mayor,
  input  logic              ucode_we,
  input  logic [ADDR_W-1:0] ucode_addr,
  input  logic [MI_W-1:0]   ucode_data,
  output logic [CW_W-1:0]   o_signal,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] pc
);

  localparam int unsigned CW_LSB   = cw_lsb(ADDR_W);
  localparam int unsigned OP_LSB   = op_lsb(ADDR_W);
  localparam int unsigned COND_LSB = cond_lsb(ADDR_W);
  localparam int unsigned POL_LSB  = pol_lsb(ADDR_W);
  localparam int unsigned TGT_LSB  = target_lsb();

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, pc_inc;
  logic [LOOP_W-1:0]   loop_q, loop_d;
  logic                err_q, err_d, done_q, done_d, busy_q, busy_d;

  logic [MI_W-1:0]     mi;
  logic [CW_W-1:0]     mi_cw;
  op_e                 mi_op;
  cond_e               mi_cond;
  logic                mi_pol;
  logic [ADDR_W-1:0]   mi_tgt;
  logic                flag, c;

  microseq_store #(
    .ADDR_W (ADDR_W),
    .MI_W   (MI_W)
  ) u_store (
    .clk   (clk),
    .we    (ucode_we && (state_q == ST_IDLE)),
    .waddr (ucode_addr),
    .wdata (ucode_data),
    .raddr (pc_q),
    .rdata (mi)
  );

  // Field decode of the current micro-instruction
  assign mi_cw   = mi[CW_LSB +: CW_W];
  assign mi_op   = op_e'(mi[OP_LSB +: OP_W]);
  assign mi_cond = cond_e'(mi[COND_LSB +: COND_W]);
  assign mi_pol  = mi[POL_LSB];
  assign mi_tgt  = mi[TGT_LSB +: ADDR_W];

  // Condition mux; polarity bit inverts the selected flag
  always_comb begin
    flag = 1'b1;
    case (mi_cond)
      COND_ZERO:  flag = zero;
      COND_NEG:   flag = neg;
      COND_MAYOR: flag = mayor;
      COND_ONE:   flag = 1'b1;
      default:    flag = 1'b1;
    endcase
    c = flag ^ mi_pol;
  end

  // Natural wrap at 2^ADDR_W
  assign pc_inc = pc_q + ADDR_W'(1);

  // Next-state, next-pc and output logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    loop_d  = loop_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_RUN;
          pc_d    = start_addr;
          loop_d  = '0;
          err_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          case (mi_op)
            OP_NEXT:   pc_d = pc_inc;
            OP_JUMP:   pc_d = mi_tgt;
            OP_BRANCH: pc_d = c ? mi_tgt : pc_inc;
            OP_LDLOOP: begin
              loop_d = mi_tgt[LOOP_W-1:0];
              pc_d   = pc_inc;
            end
            OP_LOOP: begin
              if (loop_q != '0) begin
                loop_d = loop_q - LOOP_W'(1);
                pc_d   = mi_tgt;
              end else begin
                pc_d   = pc_inc;
              end
            end
            OP_WAIT:   pc_d = c ? pc_inc : pc_q;
            OP_END: begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
            OP_ILL: begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              err_d   = 1'b1;
            end
            default:   state_d = ST_DONE;
          endcase
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      loop_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      loop_q  <= loop_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign o_signal = (state_q == ST_RUN) ? mi_cw : '0;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign pc       = pc_q;

endmodule
